hazard_ctrl: RTL

Parametrised pipeline hazard controller for the five-stage RISC-V core. It replaces the fixed single-cycle load-use detector with a per-register latency scoreboard, so loads and multi-cycle multiply results get the correct number of bubbles. It also produces E-stage forwarding selects and branch flushes. It sits beside the D/E/M/W pipeline registers and drives their stall and flush enables.

---
 rtl/hazard_pkg.sv | 43 ++++
 rtl/hazard_scoreboard.sv | 55 +++++
 rtl/hazard_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and helpers for the pipeline hazard controller.
//   fwd_sel_e      : E-stage operand forwarding select (RF / W / M)
//   lat_class_e    : latency class of the instruction sitting in E
//   lat_class()    : classify an E-stage instruction (mul beats load)
//   class_latency(): number of bubbles a dependent consumer needs
// ---------------------------------------------------------------------------
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_e;

   typedef enum logic [1:0] {
      LAT_ALU,
      LAT_LOAD,
      LAT_MUL
   } lat_class_e;

   // A multiply that is also flagged as a load is treated as a multiply.
   function automatic lat_class_e lat_class(input logic is_mul, input logic is_load);
      if (is_mul)
         return LAT_MUL;
      else if (is_load)
         return LAT_LOAD;
      else
         return LAT_ALU;
   endfunction

   function automatic int unsigned class_latency(input lat_class_e   cls,
                                                 input int unsigned  load_lat,
                                                 input int unsigned  mul_lat);
      case (cls)
         LAT_MUL:  return mul_lat;
         LAT_LOAD: return load_lat;
         default:  return 0;
      endcase
   endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Per-register latency scoreboard. Each architectural register r (1..NREG-1)
// owns a down-counter holding the number of further cycles a consumer of r
// must wait. Register 0 never holds a pending result.
// Ports:
//   clk, reset       : core clock, synchronous active-high reset
//   i_alloc          : allocate an entry this edge (producer in E, rd != 0)
//   i_alloc_rd       : register being allocated
//   i_alloc_cnt      : value loaded into the allocated counter
//   i_rs1, i_rs2     : lookup indices (D-stage sources)
//   o_busy1, o_busy2 : the looked-up register still has cycles pending
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
   parameter int NREG  = 32,
   parameter int CNT_W = 2,
   parameter int REG_W = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_alloc,
   input  logic [REG_W-1:0] i_alloc_rd,
   input  logic [CNT_W-1:0] i_alloc_cnt,
   input  logic [REG_W-1:0] i_rs1,
   input  logic [REG_W-1:0] i_rs2,
   output logic             o_busy1,
   output logic             o_busy2
);

   logic [CNT_W-1:0] r_cnt [NREG];

   // NOTE: sequential state is written with non-blocking assignments so every
   // counter sees the pre-edge value of its neighbours and of the inputs.
   // NOTE: the counter array is a small bank of flops rather than a RAM, so it
   // is cleared by reset like any other register.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NREG; r++)
            r_cnt[r] <= '0;
      end else begin
         r_cnt[0] <= '0;
         for (int r = 1; r < NREG; r++) begin
            // A new producer always replaces whatever the older one left.
            if (i_alloc && (i_alloc_rd == REG_W'(r)))
               r_cnt[r] <= i_alloc_cnt;
            else if (r_cnt[r] != '0)
               r_cnt[r] <= r_cnt[r] - 1'b1;
         end
      end
   end

   assign o_busy1 = (r_cnt[i_rs1] != '0);
   assign o_busy2 = (r_cnt[i_rs2] != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Hazard controller for the five-stage core: stalls consumers of loads and
// multi-cycle multiplies for exactly the producer's latency, flushes on taken
// branches and selects E-stage forwarding sources.
// Ports:
//   clk, reset                 : core clock, synchronous active-high reset
//   Rs1D, Rs2D                 : D-stage sources
//   Rs1E, Rs2E                 : E-stage sources (forwarding)
//   RdE, RegWriteE             : E-stage destination / write enable
//   ResultSrcE0, MulE          : E-stage instruction is load / multiply
//   PCSrcE                     : taken branch or jump resolved in E
//   RdM, RegWriteM             : M-stage destination / write enable
//   RdW, RegWriteW             : W-stage destination / write enable
//   StallF, StallD             : hold PC and IF/ID
//   FlushD, FlushE             : clear IF/ID and ID/EX
//   ForwardAE, ForwardBE       : 00 RF, 10 from M, 01 from W
// ---------------------------------------------------------------------------
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int NREG     = 32,
   parameter int LOAD_LAT = 1,
   parameter int MUL_LAT  = 3,
   parameter int CNT_W    = $clog2(((LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT) + 1),
   parameter int REG_W    = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] Rs1D,
   input  logic [REG_W-1:0] Rs2D,
   input  logic [REG_W-1:0] Rs1E,
   input  logic [REG_W-1:0] Rs2E,
   input  logic [REG_W-1:0] RdE,
   input  logic             RegWriteE,
   input  logic             ResultSrcE0,
   input  logic             MulE,
   input  logic             PCSrcE,
   input  logic [REG_W-1:0] RdM,
   input  logic             RegWriteM,
   input  logic [REG_W-1:0] RdW,
   input  logic             RegWriteW,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE
);

   lat_class_e       w_cls;
   int unsigned      w_lat;
   logic             w_alloc;
   logic [CNT_W-1:0] w_alloc_cnt;
   logic             w_busy1;
   logic             w_busy2;
   logic             w_e_hit;
   logic             w_data_stall;
   fwd_sel_e         w_fwd_a;
   fwd_sel_e         w_fwd_b;

   function automatic fwd_sel_e fwd_select(input logic [REG_W-1:0] rs);
      if (RegWriteM && (RdM != '0) && (RdM == rs))
         return FWD_M;
      else if (RegWriteW && (RdW != '0) && (RdW == rs))
         return FWD_W;
      else
         return FWD_RF;
   endfunction

   // NOTE: every signal driven from always_comb gets a default before any
   // conditional logic so no path can leave it unassigned and infer a latch.
   always_comb begin
      w_alloc_cnt = '0;
      w_cls       = lat_class(MulE, ResultSrcE0);
      w_lat       = class_latency(w_cls, LOAD_LAT, MUL_LAT);
      // The E-stage cycle itself is the first bubble, so the counter only
      // covers the remaining lat-1 cycles.
      if (w_lat != 0)
         w_alloc_cnt = CNT_W'(w_lat - 1);
   end

   assign w_alloc = RegWriteE && (RdE != '0);

   hazard_scoreboard #(
      .NREG  (NREG),
      .CNT_W (CNT_W),
      .REG_W (REG_W)
   ) u_scoreboard (
      .clk         (clk),
      .reset       (reset),
      .i_alloc     (w_alloc),
      .i_alloc_rd  (RdE),
      .i_alloc_cnt (w_alloc_cnt),
      .i_rs1       (Rs1D),
      .i_rs2       (Rs2D),
      .o_busy1     (w_busy1),
      .o_busy2     (w_busy2)
   );

   assign w_e_hit      = w_alloc && (w_lat != 0) && ((RdE == Rs1D) || (RdE == Rs2D));
   assign w_data_stall = w_e_hit || w_busy1 || w_busy2;

   // A taken branch discards the stalled consumer anyway, so flush wins.
   assign StallF = w_data_stall && !PCSrcE;
   assign StallD = w_data_stall && !PCSrcE;
   assign FlushD = PCSrcE;
   assign FlushE = w_data_stall || PCSrcE;

   assign w_fwd_a   = fwd_select(Rs1E);
   assign w_fwd_b   = fwd_select(Rs2E);
   assign ForwardAE = w_fwd_a;
   assign ForwardBE = w_fwd_b;

endmodule
